// File: rtl/alu4_pkg.sv
// Shared types for the alu4 command path.
// Command bundle layout is {sel, a, b}.
package alu4_pkg;

  localparam int ALU4_DATA_W = 4;
  localparam int ALU4_SEL_W  = 2;

  typedef struct packed {
    logic [ALU4_SEL_W-1:0]  sel;
    logic [ALU4_DATA_W-1:0] a;
    logic [ALU4_DATA_W-1:0] b;
  } alu4_cmd_t;

endpackage

// File: rtl/alu4_cmd_fifo.sv
// Synchronous FIFO of alu4 commands.
// Pointers carry an extra wrap bit for full/empty.
module alu4_cmd_fifo
  import alu4_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  alu4_cmd_t                wdata,
  output alu4_cmd_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  alu4_cmd_t      mem [DEPTH];
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;

  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                 (wptr[AW] != rptr[AW]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu4_cmd_queue.sv
// Command queue, issue register and result capture around alu4_s2.
// Define ALU4_CMDQ_OVF_EN to build the sticky overflow flag ERR.
module alu4_cmd_queue
  import alu4_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = ALU4_DATA_W
) (
  input  logic                     CLK_in,
  input  logic                     RST_in,
  input  logic                     CMD_VALID_in,
  output logic                     CMD_READY,
  input  logic [ALU4_SEL_W-1:0]    CMD_SEL_in,
  input  logic [DATA_W-1:0]        CMD_A_in,
  input  logic [DATA_W-1:0]        CMD_B_in,
  output logic [DATA_W-1:0]        A_out,
  output logic [DATA_W-1:0]        B_out,
  output logic [ALU4_SEL_W-1:0]    SEL_out,
  input  logic [DATA_W-1:0]        Y_in,
  output logic                     RES_VALID,
  output logic [DATA_W-1:0]        RES_Y,
  output logic [ALU4_SEL_W-1:0]    RES_SEL,
  input  logic                     RES_READY_in,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     ERR
);

  alu4_cmd_t wr_cmd;
  alu4_cmd_t head;
  logic      full;
  logic      empty;
  logic      push;
  logic      load;
  logic      adv;
  logic      iss_v;

  assign wr_cmd    = '{sel: CMD_SEL_in, a: CMD_A_in, b: CMD_B_in};
  assign CMD_READY = !full;
  assign push      = CMD_VALID_in && CMD_READY;
  assign adv       = iss_v && (!RES_VALID || RES_READY_in);
  assign load      = !empty && (!iss_v || adv);

  alu4_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK_in),
    .rst   (RST_in),
    .push  (push),
    .pop   (load),
    .wdata (wr_cmd),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (COUNT)
  );

  // Operand outputs only change on a load, so alu4_s2 sees stable inputs.
  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) begin
      iss_v   <= 1'b0;
      A_out   <= '0;
      B_out   <= '0;
      SEL_out <= '0;
    end else if (load) begin
      iss_v   <= 1'b1;
      A_out   <= head.a;
      B_out   <= head.b;
      SEL_out <= head.sel;
    end else if (adv) begin
      iss_v   <= 1'b0;
    end
  end

  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) begin
      RES_VALID <= 1'b0;
      RES_Y     <= '0;
      RES_SEL   <= '0;
    end else if (adv) begin
      RES_VALID <= 1'b1;
      RES_Y     <= Y_in;
      RES_SEL   <= SEL_out;
    end else if (RES_READY_in) begin
      RES_VALID <= 1'b0;
    end
  end

`ifdef ALU4_CMDQ_OVF_EN
  logic err_q;

  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) begin
      err_q <= 1'b0;
    end else if (CMD_VALID_in && !CMD_READY) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_alu4_cmd_queue.sv
// Directed bench for alu4_cmd_queue with a stand-in alu4_s2 model.
// Stand-in ALU: 0 add, 1 sub, 2 xor, 3 or.
module tb_alu4_cmd_queue;
  import alu4_pkg::*;

`ifdef ALU4_CMDQ_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic       CLK_in = 1'b0;
  logic       RST_in;
  logic       CMD_VALID_in;
  logic       CMD_READY;
  logic [1:0] CMD_SEL_in;
  logic [3:0] CMD_A_in;
  logic [3:0] CMD_B_in;
  logic [3:0] A_out;
  logic [3:0] B_out;
  logic [1:0] SEL_out;
  logic [3:0] Y_in;
  logic       RES_VALID;
  logic [3:0] RES_Y;
  logic [1:0] RES_SEL;
  logic       RES_READY_in;
  logic [2:0] COUNT;
  logic       ERR;

  int n_tests = 0;
  int n_fail  = 0;

  alu4_cmd_t  sv [8];
  logic [3:0] sy [8];
  alu4_cmd_t  fv [7];
  logic [3:0] fy [6];
  alu4_cmd_t  pv [6];
  logic [3:0] py [6];
  int         pc [10];
  logic       prv [10];
  int         pix [10];
  alu4_cmd_t  qv [5];
  int         dc [5];

  alu4_cmd_queue dut (
    .CLK_in       (CLK_in),
    .RST_in       (RST_in),
    .CMD_VALID_in (CMD_VALID_in),
    .CMD_READY    (CMD_READY),
    .CMD_SEL_in   (CMD_SEL_in),
    .CMD_A_in     (CMD_A_in),
    .CMD_B_in     (CMD_B_in),
    .A_out        (A_out),
    .B_out        (B_out),
    .SEL_out      (SEL_out),
    .Y_in         (Y_in),
    .RES_VALID    (RES_VALID),
    .RES_Y        (RES_Y),
    .RES_SEL      (RES_SEL),
    .RES_READY_in (RES_READY_in),
    .COUNT        (COUNT),
    .ERR          (ERR)
  );

  always #5 CLK_in = ~CLK_in;

  function automatic logic [3:0] alu_ref(
    input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a | b;
    endcase
  endfunction

  assign Y_in = alu_ref(SEL_out, A_out, B_out);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_in);
    #1;
  endtask

  task automatic drive(input alu4_cmd_t c);
    CMD_VALID_in = 1'b1;
    CMD_SEL_in   = c.sel;
    CMD_A_in     = c.a;
    CMD_B_in     = c.b;
  endtask

  task automatic check_reset(input string p);
    check({p, "_ready"}, 32'(CMD_READY), 32'd1);
    check({p, "_a"},     32'(A_out),     32'd0);
    check({p, "_b"},     32'(B_out),     32'd0);
    check({p, "_sel"},   32'(SEL_out),   32'd0);
    check({p, "_rv"},    32'(RES_VALID), 32'd0);
    check({p, "_ry"},    32'(RES_Y),     32'd0);
    check({p, "_rsel"},  32'(RES_SEL),   32'd0);
    check({p, "_cnt"},   32'(COUNT),     32'd0);
    check({p, "_err"},   32'(ERR),       32'd0);
  endtask

  task automatic single(input logic [1:0] s, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] y);
    drive('{sel: s, a: a, b: b});
    tick();
    CMD_VALID_in = 1'b0;
    check("single_cnt1", 32'(COUNT), 32'd1);
    check("single_rv0", 32'(RES_VALID), 32'd0);
    tick();
    check("single_a", 32'(A_out), 32'(a));
    check("single_b", 32'(B_out), 32'(b));
    check("single_sel", 32'(SEL_out), 32'(s));
    check("single_rv1", 32'(RES_VALID), 32'd0);
    tick();
    check("single_rv2", 32'(RES_VALID), 32'd1);
    check("single_y", 32'(RES_Y), 32'(y));
    check("single_rsel", 32'(RES_SEL), 32'(s));
    tick();
    check("single_rv3", 32'(RES_VALID), 32'd0);
  endtask

  task automatic stream(input int n);
    for (int c = 0; c < n + 2; c++) begin
      if (c < n) drive(sv[c]);
      else CMD_VALID_in = 1'b0;
      tick();
      if (c < n)
        check($sformatf("strm_cnt%0d", c), 32'(COUNT), 32'd1);
      if (c >= 2) begin
        check($sformatf("strm_rv%0d", c - 2), 32'(RES_VALID), 32'd1);
        check($sformatf("strm_y%0d", c - 2), 32'(RES_Y), 32'(sy[c-2]));
        check($sformatf("strm_sel%0d", c - 2), 32'(RES_SEL),
              32'(sv[c-2].sel));
      end
    end
    CMD_VALID_in = 1'b0;
    tick();
    check("strm_rv_end", 32'(RES_VALID), 32'd0);
    check("strm_cnt_end", 32'(COUNT), 32'd0);
  endtask

  initial begin
    fv  = '{'{2'd0, 4'd1, 4'd2}, '{2'd1, 4'd2, 4'd3},
            '{2'd2, 4'd3, 4'd4}, '{2'd3, 4'd4, 4'd5},
            '{2'd0, 4'd5, 4'd6}, '{2'd1, 4'd6, 4'd7},
            '{2'd2, 4'd7, 4'd8}};
    fy  = '{4'h3, 4'hF, 4'h7, 4'h5, 4'hB, 4'hF};
    dc  = '{3, 2, 1, 0, 0};
    pv  = '{'{2'd0, 4'd1, 4'd1}, '{2'd1, 4'd5, 4'd2},
            '{2'd2, 4'd6, 4'd3}, '{2'd3, 4'd2, 4'd4},
            '{2'd0, 4'd9, 4'd9}, '{2'd1, 4'd3, 4'd5}};
    py  = '{4'h2, 4'h3, 4'h5, 4'h6, 4'h2, 4'hE};
    pc  = '{1, 1, 1, 2, 2, 2, 1, 0, 0, 0};
    prv = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    pix = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 0};
    qv  = '{'{2'd1, 4'd9, 4'd2}, '{2'd2, 4'd5, 4'd3},
            '{2'd3, 4'd4, 4'd4}, '{2'd0, 4'd6, 4'd1},
            '{2'd1, 4'd7, 4'd7}};

    RST_in       = 1'b1;
    CMD_VALID_in = 1'b0;
    CMD_SEL_in   = '0;
    CMD_A_in     = '0;
    CMD_B_in     = '0;
    RES_READY_in = 1'b1;
    tick();
    tick();
    check_reset("rst0");
    RST_in = 1'b0;
    tick();

    single(2'd1, 4'd2, 4'd3, 4'hF);

    sv[0] = '{2'd1, 4'd10, 4'd6}; sy[0] = 4'h4;
    sv[1] = '{2'd2, 4'd8,  4'd5}; sy[1] = 4'hD;
    sv[2] = '{2'd2, 4'd3,  4'd4}; sy[2] = 4'h7;
    sv[3] = '{2'd3, 4'd5,  4'd0}; sy[3] = 4'h5;
    stream(4);

    RES_READY_in = 1'b0;
    check("full_err0", 32'(ERR), 32'd0);
    for (int c = 0; c < 7; c++) begin
      drive(fv[c]);
      tick();
      if (c == 4) begin
        check("full_rdy5", 32'(CMD_READY), 32'd1);
        check("full_cnt5", 32'(COUNT), 32'd3);
      end
      if (c == 5) begin
        check("full_rdy6", 32'(CMD_READY), 32'd0);
        check("full_cnt6", 32'(COUNT), 32'd4);
      end
    end
    CMD_VALID_in = 1'b0;
    check("full_cnt7", 32'(COUNT), 32'd4);
    check("full_err", 32'(ERR), 32'(OVF));
    check("full_rv", 32'(RES_VALID), 32'd1);
    check("drain_y0", 32'(RES_Y), 32'(fy[0]));
    check("drain_sel0", 32'(RES_SEL), 32'(fv[0].sel));

    RES_READY_in = 1'b1;
    for (int k = 1; k < 6; k++) begin
      tick();
      check($sformatf("drain_rv%0d", k), 32'(RES_VALID), 32'd1);
      check($sformatf("drain_y%0d", k), 32'(RES_Y), 32'(fy[k]));
      check($sformatf("drain_sel%0d", k), 32'(RES_SEL), 32'(fv[k].sel));
      check($sformatf("drain_cnt%0d", k), 32'(COUNT), 32'(dc[k-1]));
    end
    tick();
    check("drain_rv_end", 32'(RES_VALID), 32'd0);

    sv[0] = '{2'd0, 4'd15, 4'd1};  sy[0] = 4'h0;
    sv[1] = '{2'd1, 4'd0,  4'd1};  sy[1] = 4'hF;
    sv[2] = '{2'd2, 4'd12, 4'd10}; sy[2] = 4'h6;
    sv[3] = '{2'd3, 4'd9,  4'd6};  sy[3] = 4'hF;
    sv[4] = '{2'd0, 4'd7,  4'd7};  sy[4] = 4'hE;
    sv[5] = '{2'd1, 4'd9,  4'd4};  sy[5] = 4'h5;
    sv[6] = '{2'd2, 4'd15, 4'd15}; sy[6] = 4'h0;
    sv[7] = '{2'd3, 4'd8,  4'd1};  sy[7] = 4'h9;
    stream(8);

    for (int c = 0; c < 10; c++) begin
      if (c < 6) drive(pv[c]);
      else CMD_VALID_in = 1'b0;
      RES_READY_in = (c >= 4);
      tick();
      check($sformatf("pp_cnt%0d", c), 32'(COUNT), 32'(pc[c]));
      check($sformatf("pp_rv%0d", c), 32'(RES_VALID), 32'(prv[c]));
      if (prv[c]) begin
        check($sformatf("pp_y%0d", c), 32'(RES_Y), 32'(py[pix[c]]));
        check($sformatf("pp_sel%0d", c), 32'(RES_SEL),
              32'(pv[pix[c]].sel));
      end
    end

    RES_READY_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(qv[c]);
      tick();
    end
    CMD_VALID_in = 1'b0;
    check("mid_cnt", 32'(COUNT), 32'd3);
    check("mid_rv", 32'(RES_VALID), 32'd1);
    check("mid_a", 32'(A_out), 32'(qv[1].a));
    RST_in = 1'b1;
    #1;
    check_reset("rst1");
    tick();
    RST_in       = 1'b0;
    RES_READY_in = 1'b1;
    tick();
    single(2'd0, 4'd4, 4'd5, 4'h9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
